mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 15 +
 rtl/mem_loader.sv | 113 +++++++++++
 tb/tb_mem_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: state encoding and byte width; READ/CHECK exist only with MEM_LOADER_READBACK_EN
package mem_loader_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {
    IDLE,
    BYTE_HI,
    BYTE_LO,
    WRITE,
`ifdef MEM_LOADER_READBACK_EN
    READ,
    CHECK,
`endif
    DONE
  } state_e;
endpackage

// File: rtl/mem_loader.sv
// mem_loader: packs a byte stream into 16-bit words written to a 1RW RAM; MEM_LOADER_READBACK_EN adds read-back verification
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW:0]       num_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_write,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       word_cnt,
  output logic              error
);
  state_e            state_q, state_d;
  logic [AW:0]       num_q, num_d, cnt_q, cnt_d, cnt_now;
  logic [AW-1:0]     addr_q, addr_d;
  logic [BYTE_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              err_q, err_d, last;
  // count including the word being written this cycle, so WRITE and CHECK share one end test
  assign cnt_now = (state_q == WRITE) ? cnt_q + 1'b1 : cnt_q;
  assign last = (cnt_now == num_q);
  assign in_ready = (state_q == BYTE_HI) || (state_q == BYTE_LO);
  assign ram_write = (state_q == WRITE);
  assign ram_wdata = {hi_q, lo_q};
  assign ram_addr = addr_q;
  assign busy = (state_q != IDLE) && (state_q != DONE);
  assign done = (state_q == DONE);
  assign word_cnt = cnt_q;
`ifdef MEM_LOADER_READBACK_EN
  assign error = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign error = 1'b0;
`endif
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      err_q <= err_d;
    end
  end
  // next-state: collect two bytes, write, optionally read back, then advance or finish
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    hi_d = hi_q;
    lo_d = lo_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        num_d = num_words;
        cnt_d = '0;
        err_d = 1'b0;
        addr_d = '0;
        state_d = (num_words == '0) ? DONE : BYTE_HI;
      end
      BYTE_HI: if (in_valid) begin
        hi_d = in_data;
        state_d = BYTE_LO;
      end
      BYTE_LO: if (in_valid) begin
        lo_d = in_data;
        state_d = WRITE;
      end
`ifdef MEM_LOADER_READBACK_EN
      WRITE: begin
        cnt_d = cnt_now;
        state_d = READ;
      end
      READ: state_d = CHECK;
      CHECK: begin
        err_d = err_q | (ram_rdata != {hi_q, lo_q});
        state_d = last ? DONE : BYTE_HI;
        addr_d = last ? addr_q : addr_q + 1'b1;
      end
`else
      WRITE: begin
        cnt_d = cnt_now;
        state_d = last ? DONE : BYTE_HI;
        addr_d = last ? addr_q : addr_q + 1'b1;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: table-driven, hand-written and randomized loads checked against a word-level model (honours MEM_LOADER_READBACK_EN)
module tb_mem_loader;
  localparam int AW = 4;
  localparam int DW = 16;
`ifdef MEM_LOADER_READBACK_EN
  localparam int CPW = 5;
  localparam logic [15:0] STUCK = 16'hFFFE;
`else
  localparam int CPW = 3;
  localparam logic [15:0] STUCK = 16'hFFFF;
`endif
  typedef struct {
    int          n;
    logic [63:0] data;
    int          exp_cnt;
    bit          gaps;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [AW:0] num_words = '0;
  logic [7:0] in_data = '0;
  logic in_ready, ram_write, busy, done, error;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, rdata;
  logic [AW:0] word_cnt;
  logic [15:0] mem [2**AW];
  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, busy_cyc = 0, dbl = 0;
  logic prev_wr = 0;
  logic [AW-1:0] wr_addr [$];
  logic [15:0] wr_data [$];
  logic [7:0] src [$];
  logic [15:0] words [$];
  vec_t vec [6];

  always #5 clk = ~clk;

  mem_loader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_wdata(ram_wdata),
    .ram_rdata(rdata), .busy(busy), .done(done), .word_cnt(word_cnt), .error(error)
  );

  // RAM with registered read; in readback builds bit0 is stuck at 0
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_wdata & STUCK;
    rdata <= mem[ram_addr];
  end

  // observe writes, done pulses, busy cycles and back-to-back writes
  always @(negedge clk) begin
    if (ram_write) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_wdata);
    end
    if (ram_write && prev_wr) dbl <= dbl + 1;
    prev_wr <= ram_write;
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input string tag, input int n, input int exp_cnt, input bit gaps, input int poke);
    int d0, w0, b0, x0, t, idx;
    bit err_exp;
    logic [15:0] w;
    d0 = done_cnt; w0 = wr_addr.size(); b0 = busy_cyc; x0 = dbl;
    src.delete();
    err_exp = 0;
    foreach (words[i]) begin
      w = words[i];
      src.push_back(w[15:8]);
      src.push_back(w[7:0]);
      err_exp |= ((w & STUCK) != w);
    end
    @(negedge clk);
    start = 1;
    num_words = n[AW:0];
    @(negedge clk);
    start = 0;
    t = 0;
    idx = 0;
    while (!done && t < 4000) begin
      start = (t == poke);
      num_words = (t == poke) ? 5'd5 : n[AW:0];
      in_valid = (idx < src.size()) && (!gaps || $urandom_range(0, 1) == 1);
      in_data = in_valid ? src[idx] : 8'($urandom);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      t++;
    end
    start = 0;
    in_valid = 0;
    chk({tag, " done reached"}, done, 1);
    chk({tag, " busy at done"}, busy, 0);
    if (!gaps) chk({tag, " cycles"}, t, n * CPW);
    @(negedge clk);
    chk({tag, " busy after"}, busy, 0);
    chk({tag, " word_cnt"}, word_cnt, exp_cnt);
    chk({tag, " done pulses"}, done_cnt - d0, 1);
    chk({tag, " writes"}, wr_addr.size() - w0, exp_cnt);
    chk({tag, " double write"}, dbl - x0, 0);
    chk({tag, " error"}, error, err_exp);
    if (!gaps) chk({tag, " busy cycles"}, busy_cyc - b0, n * CPW);
    for (int i = 0; i < exp_cnt; i++) begin
      if (w0 + i < wr_addr.size()) begin
        chk({tag, " wr addr"}, wr_addr[w0 + i], i);
        chk({tag, " wr data"}, wr_data[w0 + i], words[i]);
      end
      chk({tag, " ram"}, mem[i], words[i] & STUCK);
    end
  endtask

  initial begin
    int d0, w0, t, idx, hits;
    vec[0] = '{3, 64'h0000_00FF_ABCD_1234, 3, 0};
    vec[1] = '{0, 64'h0, 0, 0};
    vec[2] = '{1, 64'h0000_0000_0000_0001, 1, 0};
    vec[3] = '{4, 64'hFFFE_0000_8000_7FFE, 4, 0};
    vec[4] = '{2, 64'h0000_0000_ABCD_1234, 2, 1};
    vec[5] = '{2, 64'h0000_0000_A5A4_5A5A, 2, 0};
    repeat (3) @(negedge clk);
    chk("rst state", {in_ready, ram_write, busy, done, error}, 0);
    chk("rst addr", ram_addr, 0);
    chk("rst wdata", ram_wdata, 0);
    chk("rst word_cnt", word_cnt, 0);
    rst = 0;
    foreach (vec[v]) begin
      words.delete();
      for (int i = 0; i < vec[v].n; i++) words.push_back(vec[v].data[16 * i +: 16]);
      load($sformatf("vec%0d", v), vec[v].n, vec[v].exp_cnt, vec[v].gaps, -1);
    end
    // reset after the high byte of word 1
    words = {16'h1122, 16'h3344};
    src = {8'h11, 8'h22, 8'h33};
    d0 = done_cnt; w0 = wr_addr.size();
    @(negedge clk);
    start = 1;
    num_words = 5'd2;
    @(negedge clk);
    start = 0;
    t = 0;
    idx = 0;
    while (idx < 3 && t < 50) begin
      in_valid = 1;
      in_data = src[idx];
      if (in_ready) idx++;
      @(negedge clk);
      t++;
    end
    in_valid = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    chk("midrst state", {in_ready, ram_write, busy, done}, 0);
    chk("midrst word_cnt", word_cnt, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("midrst done", done_cnt - d0, 0);
    chk("midrst writes", wr_addr.size() - w0, 1);
    hits = 0;
    for (int i = w0; i < wr_addr.size(); i++) if (wr_addr[i] == 1) hits++;
    chk("midrst addr1", hits, 0);
    words = {16'h55AA};
    load("after rst", 1, 1, 0, -1);
    // start while busy is ignored
    words = {16'h0F0E, 16'h2468};
    load("busy start", 2, 2, 0, 2);
    // fill the whole RAM
    words.delete();
    for (int i = 0; i < 2 ** AW; i++) words.push_back(16'($urandom));
    load("fill", 2 ** AW, 2 ** AW, 1, -1);
    chk("fill last addr", ram_addr, 2 ** AW - 1);
    // randomized loads
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 8);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      load($sformatf("rand%0d", r), n, n, r[0], -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
